pe_link_tx: RTL and testbench
=============================

Name: pe_link_tx

Overview:
Parametrised, credit-based transmit side of a PE-to-mesh link, generalising the fixed four-port PE link to NUM_CH independent channels with configurable flit width, local buffer depth and receiver credit count. Each channel buffers flits written by the PE, then forwards them on its own tx/data_o link only while it holds credits. Each credit_i pulse from the mesh returns one credit. Adds behaviour the plain link lacks: per-channel enable, observable credit level, and sticky error flags for buffer overflow and credit overflow.

Parameters:
FLIT_WIDTH  16  bits per flit
NUM_CH  4  number of independent link channels
DEPTH  4  local FIFO depth per channel in flits; power of 2, >= 2
CREDITS  4  initial and maximum credits per channel (receiver buffer depth), >= 1

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
wr_en  in  NUM_CH  per-channel flit write strobe from PE
wr_data  in  NUM_CH*FLIT_WIDTH  write flits; channel c occupies bits [c*FLIT_WIDTH +: FLIT_WIDTH]
wr_full  out  NUM_CH  channel FIFO holds DEPTH flits
ch_enable  in  NUM_CH  channel c may transmit when 1
tx  out  NUM_CH  flit valid on channel c link (registered)
data_o  out  NUM_CH*FLIT_WIDTH  link flits, packed like wr_data (registered)
credit_i  in  NUM_CH  one-cycle pulse returns one credit to channel c
credit_cnt  out  NUM_CH*$clog2(CREDITS+1)  current credits per channel, packed
ovf_err  out  NUM_CH  sticky: write attempted while full
crd_err  out  NUM_CH  sticky: credit returned while already at CREDITS

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=0, data_o=0, ovf_err=0, crd_err=0.
  - FIFOs empty, so wr_full=0.
  - credit_cnt=CREDITS on every channel.
  - Reset mid-transfer discards buffered flits and restores full credits.
- Channels are fully independent. No arbitration and no cross-channel interaction.
- FIFO write, per channel, at a rising edge:
  - If wr_en=1 and the FIFO is not full (pre-edge count < DEPTH), store the flit at the write pointer and increment the pointer (wraps mod DEPTH).
  - If wr_en=1 while full, drop the flit and set ovf_err. This holds even if a send pops the FIFO on the same edge; fullness uses the pre-edge count.
- wr_full is a combinational decode of the registered count (count==DEPTH).
- Send decision, per channel, at each rising edge, using pre-edge state:
  - send = (count>0) && (credit_cnt>0) && ch_enable.
  - If send: tx<=1, data_o<=head flit, read pointer++ (wraps), count--, one credit consumed.
  - Else: tx<=0 and data_o holds its previous value.
- Latency: a flit written at edge k is sent at edge k+1, so tx is high from edge k+1 to edge k+2. Sustained throughput is 1 flit/cycle/channel while credits last.
- Simultaneous push and pop on a non-full FIFO: count unchanged and both pointers advance.
- Credit update, per channel, at each rising edge:
  - next = credit_cnt - send + credit_i.
  - If credit_i=1, send=0 and credit_cnt==CREDITS: credit_cnt stays CREDITS (saturates) and crd_err is set.
  - If credit_i=1 and send=1 on the same edge: net unchanged, no error.
- Zero credits: the channel stalls with tx=0 and flits stay buffered. Transmission resumes on the edge after a credit_i pulse raises credit_cnt to 1.
- ch_enable deassertion takes effect on the next edge. A flit already launched completes; no flit is lost.
- ovf_err and crd_err are cleared only by reset.

Test Plan:
- Reset then idle (CREDITS=4) -> all credit_cnt=4, tx=0, wr_full=0, both error flags 0.
- Ch0: write 0xA001 at edge 1 with enable=1 -> tx[0]=1 and data_o[0]=0xA001 after edge 2 only, credit_cnt[0]=3; no other channel's tx toggles.
- Ch1: write 6 flits 0x0..0x5 on consecutive edges, no credit_i -> exactly 4 flits leave in order 0x0..0x3 with tx high on 4 consecutive cycles; credit_cnt=0, 0x4/0x5 held. One credit_i pulse -> 0x4 sent next edge, credit_cnt stays 0.
- Ch2: enable=0, write 5 flits with DEPTH=4 -> wr_full=1 after 4 writes, 5th dropped, ovf_err[2]=1. Enable=1 with credits -> exactly 4 flits out, in order.
- Ch3: credit_i with credit_cnt=4 and idle -> credit_cnt stays 4, crd_err[3]=1. With credit_cnt=2, credit_i coincident with a send -> credit_cnt stays 2, no error.
- Assert reset mid-stream with ch1 holding 2 flits and credit_cnt=1 -> tx drops immediately, credit_cnt=4, wr_full=0. After release, no stale flit is transmitted.

Source files
------------

// File: rtl/pe_link_tx.sv
// Credit-based transmit side of a PE-to-mesh link.
// NUM_CH independent channels. Each channel has a local flit FIFO and a
// credit counter, and a registered tx/data_o output stage.
// A channel forwards its head flit only while it holds credits and is enabled.
module pe_link_tx #(
  parameter int unsigned FLIT_WIDTH = 16,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DEPTH      = 4,  // power of 2, >= 2
  parameter int unsigned CREDITS    = 4   // >= 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_CH-1:0]                    wr_en,
  input  logic [NUM_CH*FLIT_WIDTH-1:0]         wr_data,
  output logic [NUM_CH-1:0]                    wr_full,
  input  logic [NUM_CH-1:0]                    ch_enable,
  output logic [NUM_CH-1:0]                    tx,
  output logic [NUM_CH*FLIT_WIDTH-1:0]         data_o,
  input  logic [NUM_CH-1:0]                    credit_i,
  output logic [NUM_CH*$clog2(CREDITS+1)-1:0]  credit_cnt,
  output logic [NUM_CH-1:0]                    ovf_err,
  output logic [NUM_CH-1:0]                    crd_err
);

  localparam int unsigned CW = $clog2(CREDITS + 1);  // credit counter width
  localparam int unsigned PW = $clog2(DEPTH);        // FIFO pointer width
  localparam int unsigned NW = $clog2(DEPTH + 1);    // FIFO occupancy width

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

    logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]         count_q, count_d;
    logic [CW-1:0]         crd_q, crd_d;
    logic [FLIT_WIDTH-1:0] data_q;
    logic                  tx_q, ovf_q, crd_err_q;
    logic                  full, push, send, crd_sat;

    // Push/pop decode from pre-edge state; a full FIFO drops the write even if it pops.
    always_comb begin
      full = (count_q == NW'(DEPTH));
      push = wr_en[c] && !full;
      send = (count_q != '0) && (crd_q != '0) && ch_enable[c];
    end

    // Occupancy next state: simultaneous push and pop leaves the count unchanged.
    always_comb begin
      count_d = count_q;
      unique case ({push, send})
        2'b10:   count_d = count_q + NW'(1);
        2'b01:   count_d = count_q - NW'(1);
        default: count_d = count_q;
      endcase
    end

    // Credit next state: consume on send, return on credit_i, saturate at CREDITS.
    always_comb begin
      crd_d   = crd_q;
      crd_sat = 1'b0;
      if (send && !credit_i[c]) begin
        crd_d = crd_q - CW'(1);
      end else if (!send && credit_i[c]) begin
        if (crd_q == CW'(CREDITS)) begin
          crd_sat = 1'b1;
        end else begin
          crd_d = crd_q + CW'(1);
        end
      end
    end

    // Flit storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clock) begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data[c*FLIT_WIDTH +: FLIT_WIDTH];
      end
    end

    // Channel state, registered link outputs and sticky error flags.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
        crd_q     <= CW'(CREDITS);
        tx_q      <= 1'b0;
        data_q    <= '0;
        ovf_q     <= 1'b0;
        crd_err_q <= 1'b0;
      end else begin
        count_q <= count_d;
        crd_q   <= crd_d;
        tx_q    <= send;
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
        if (send) begin
          data_q   <= mem_q[rd_ptr_q];
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        if (wr_en[c] && full) begin
          ovf_q <= 1'b1;
        end
        if (crd_sat) begin
          crd_err_q <= 1'b1;
        end
      end
    end

    assign wr_full[c]                              = full;
    assign tx[c]                                   = tx_q;
    assign data_o[c*FLIT_WIDTH +: FLIT_WIDTH]      = data_q;
    assign credit_cnt[c*CW +: CW]                  = crd_q;
    assign ovf_err[c]                              = ovf_q;
    assign crd_err[c]                              = crd_err_q;

  end : g_ch

endmodule

// File: tb/tb_pe_link_tx.sv
// Self-checking bench for pe_link_tx: directed steps followed by a random phase,
// all checked against a queue-based reference model of each channel.
module tb_pe_link_tx;

  localparam int FW      = 16;
  localparam int NCH     = 4;
  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;
  localparam int CW      = $clog2(CREDITS + 1);

  logic                clock = 1'b0;
  logic                reset;
  logic [NCH-1:0]      wr_en;
  logic [NCH*FW-1:0]   wr_data;
  logic [NCH-1:0]      wr_full;
  logic [NCH-1:0]      ch_enable;
  logic [NCH-1:0]      tx;
  logic [NCH*FW-1:0]   data_o;
  logic [NCH-1:0]      credit_i;
  logic [NCH*CW-1:0]   credit_cnt;
  logic [NCH-1:0]      ovf_err;
  logic [NCH-1:0]      crd_err;

  always #5 clock = ~clock;

  pe_link_tx #(
    .FLIT_WIDTH (FW),
    .NUM_CH     (NCH),
    .DEPTH      (DEPTH),
    .CREDITS    (CREDITS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_full    (wr_full),
    .ch_enable  (ch_enable),
    .tx         (tx),
    .data_o     (data_o),
    .credit_i   (credit_i),
    .credit_cnt (credit_cnt),
    .ovf_err    (ovf_err),
    .crd_err    (crd_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: one queue per channel plus integer credit counts.
  logic [FW-1:0] mq [NCH][$];
  int            m_cr   [NCH];
  logic          m_tx   [NCH];
  logic [FW-1:0] m_data [NCH];
  logic          m_ovf  [NCH];
  logic          m_crd  [NCH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_cr[c]   = CREDITS;
      m_tx[c]   = 1'b0;
      m_data[c] = '0;
      m_ovf[c]  = 1'b0;
      m_crd[c]  = 1'b0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      int snd;
      int was_full;
      snd      = (mq[c].size() > 0 && m_cr[c] > 0 && ch_enable[c]) ? 1 : 0;
      was_full = (mq[c].size() == DEPTH) ? 1 : 0;
      if (snd == 1) begin
        m_tx[c]   = 1'b1;
        m_data[c] = mq[c].pop_front();
      end else begin
        m_tx[c] = 1'b0;
      end
      if (wr_en[c]) begin
        if (was_full == 1) m_ovf[c] = 1'b1;
        else mq[c].push_back(wr_data[c*FW +: FW]);
      end
      m_cr[c] = m_cr[c] - snd + (credit_i[c] ? 1 : 0);
      if (m_cr[c] > CREDITS) begin
        m_cr[c]  = CREDITS;
        m_crd[c] = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [NCH-1:0]    etx, efull, eovf, ecrd;
    logic [NCH*FW-1:0] edata;
    logic [NCH*CW-1:0] ecc;
    for (int c = 0; c < NCH; c++) begin
      etx[c]             = m_tx[c];
      efull[c]           = (mq[c].size() == DEPTH);
      eovf[c]            = m_ovf[c];
      ecrd[c]            = m_crd[c];
      edata[c*FW +: FW]  = m_data[c];
      ecc[c*CW +: CW]    = CW'(m_cr[c]);
    end
    chk({tag, "/tx"},         64'(tx),         64'(etx));
    chk({tag, "/data_o"},     64'(data_o),     64'(edata));
    chk({tag, "/wr_full"},    64'(wr_full),    64'(efull));
    chk({tag, "/credit_cnt"}, 64'(credit_cnt), 64'(ecc));
    chk({tag, "/ovf_err"},    64'(ovf_err),    64'(eovf));
    chk({tag, "/crd_err"},    64'(crd_err),    64'(ecrd));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    compare_all(tag);
  endtask

  task automatic put(input int c, input logic [FW-1:0] v);
    wr_data[c*FW +: FW] = v;
  endtask

  initial begin
    int k;
    reset     = 1'b0;
    wr_en     = '0;
    wr_data   = '0;
    ch_enable = '1;
    credit_i  = '0;
    model_reset();

    // Reset state
    #12;
    compare_all("reset");
    chk("reset_credits", 64'(credit_cnt), 64'h924);
    @(posedge clock);
    #1;
    reset = 1'b1;
    step("idle");
    step("idle");

    // Ch0: single flit, one-cycle latency
    wr_en = 4'b0001;
    put(0, 16'hA001);
    step("ch0_wr");
    chk("ch0_no_tx_at_write", 64'(tx), 64'h0);
    wr_en = '0;
    step("ch0_send");
    chk("ch0_tx", 64'(tx), 64'h1);
    chk("ch0_data", 64'(data_o[15:0]), 64'hA001);
    chk("ch0_credit", 64'(credit_cnt[2:0]), 64'd3);
    step("ch0_after");
    chk("ch0_tx_low", 64'(tx), 64'h0);
    credit_i = 4'b0001;
    step("ch0_ret");
    credit_i = '0;
    chk("ch0_credit_back", 64'(credit_cnt[2:0]), 64'd4);

    // Ch1: burst of 6 with 4 credits
    for (int i = 0; i < 6; i++) begin
      wr_en = 4'b0010;
      put(1, FW'(i));
      step("ch1_burst");
      chk("ch1_burst_tx", 64'(tx[1]), 64'((i >= 1 && i <= 4) ? 1 : 0));
    end
    wr_en = '0;
    step("ch1_stall");
    step("ch1_stall");
    chk("ch1_zero_credit", 64'(credit_cnt[5:3]), 64'd0);
    chk("ch1_stalled", 64'(tx[1]), 64'd0);
    credit_i = 4'b0010;
    step("ch1_credit");
    credit_i = '0;
    chk("ch1_one_credit", 64'(credit_cnt[5:3]), 64'd1);
    step("ch1_resume");
    chk("ch1_resume_tx", 64'(tx[1]), 64'd1);
    chk("ch1_resume_data", 64'(data_o[31:16]), 64'h4);
    chk("ch1_resume_credit", 64'(credit_cnt[5:3]), 64'd0);
    step("ch1_hold");
    chk("ch1_hold_tx", 64'(tx[1]), 64'd0);

    // Ch2: fill while disabled, overflow, then drain
    ch_enable[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 4'b0100;
      put(2, FW'(16'h20 + i));
      step("ch2_fill");
      if (i == 3) chk("ch2_full_no_ovf", 64'({wr_full[2], ovf_err[2]}), 64'b10);
    end
    chk("ch2_ovf", 64'({wr_full[2], ovf_err[2]}), 64'b11);
    wr_en        = '0;
    ch_enable[2] = 1'b1;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      step("ch2_drain");
      if (tx[2]) begin
        chk("ch2_order", 64'(data_o[47:32]), 64'(16'h20 + k));
        k++;
      end
    end
    chk("ch2_count", 64'(k), 64'd4);

    // Ch3: credit return coincident with send, then saturation
    for (int i = 0; i < 3; i++) begin
      wr_en = 4'b1000;
      put(3, FW'(16'h30 + i));
      step("ch3_wr");
    end
    wr_en    = '0;
    credit_i = 4'b1000;
    step("ch3_coincident");
    chk("ch3_coinc_credit", 64'(credit_cnt[11:9]), 64'd2);
    chk("ch3_coinc_tx", 64'(tx[3]), 64'd1);
    chk("ch3_coinc_noerr", 64'(crd_err[3]), 64'd0);
    step("ch3_ret");
    step("ch3_ret");
    step("ch3_sat");
    credit_i = '0;
    chk("ch3_sat_credit", 64'(credit_cnt[11:9]), 64'd4);
    chk("ch3_sat_err", 64'(crd_err[3]), 64'd1);

    // Reset mid-stream: ch1 holds 2 flits with 1 credit, ch0 transmitting
    ch_enable[1] = 1'b0;
    wr_en        = 4'b0011;
    put(1, 16'h0006);
    put(0, 16'h0B00);
    credit_i     = 4'b0010;
    step("pre_reset");
    wr_en    = '0;
    credit_i = '0;
    step("pre_reset");
    chk("pre_reset_tx0", 64'(tx[0]), 64'd1);
    chk("pre_reset_ch1_credit", 64'(credit_cnt[5:3]), 64'd1);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("async_reset");
    chk("async_reset_tx", 64'(tx), 64'h0);
    chk("async_reset_credits", 64'(credit_cnt), 64'h924);
    chk("async_reset_full", 64'(wr_full), 64'h0);
    @(posedge clock);
    #1;
    compare_all("in_reset");
    reset     = 1'b1;
    ch_enable = '1;
    for (int i = 0; i < 4; i++) begin
      step("post_reset");
      chk("no_stale_tx", 64'(tx), 64'h0);
    end

    // Random phase
    for (int i = 0; i < 400; i++) begin
      wr_en     = NCH'($urandom);
      wr_data   = {$urandom, $urandom};
      ch_enable = NCH'($urandom | $urandom);
      credit_i  = NCH'($urandom & $urandom);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
